// File: rtl/median_filter.sv
// Three-tap 1-D median stage: buffers an image during LOAD, then replays it
// through a clamped 3-pixel median window in PROC, one pixel per clock.
module median_filter #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] image_input,
  input  logic       enable,
  input  logic       enable_process,
  output logic [7:0] image_output,
  output logic       out_valid,
  output logic       finish,
  output logic       overflow
);

  typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;

  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic [AW:0]   n;
  logic [AW+1:0] cnt, n_ext;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data, w0, w1;
  logic [AW-1:0] rd_addr;
  logic          full, wr_try, wr_en, out_en, last;

  function automatic logic [7:0] med3(input logic [7:0] a, b, c);
    logic [7:0] lo, hi, hc;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    hc = (hi < c) ? hi : c;
    return (lo > hc) ? lo : hc;
  endfunction

  assign n_ext  = {1'b0, n};
  assign full   = (n == N_MAX);
  assign wr_try = (state == LOAD) && enable && !enable_process;
  assign wr_en  = wr_try && !full && !rst;
  // cnt counts PROC cycles; reads past the last pixel re-read it (right clamp)
  assign rd_addr = (cnt < n_ext) ? cnt[AW-1:0] : AW'(n - (AW+1)'(1));
  assign out_en  = (state == PROC) && (cnt >= (AW+2)'(2)) && (cnt < n_ext + (AW+2)'(2));
  assign last    = (state == PROC) && (cnt == n_ext + (AW+2)'(2));

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (enable_process) state_nx = (n == '0) ? DONE : PROC;
      PROC:    if (last) state_nx = DONE;
      default: state_nx = DONE;
    endcase
  end

  // Buffer is never cleared; read port is always registered.
  always_ff @(posedge clk) begin
    if (wr_en) mem[n[AW-1:0]] <= image_input;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      n            <= '0;
      cnt          <= '0;
      w0           <= '0;
      w1           <= '0;
      image_output <= '0;
      out_valid    <= 1'b0;
      finish       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_en) n <= n + (AW+1)'(1);
      if (wr_try && full) overflow <= 1'b1;
      cnt <= (state == PROC) ? cnt + (AW+2)'(1) : '0;
      // First pixel entering the window also fills the left tap (left clamp)
      w1 <= (cnt == (AW+2)'(1)) ? rd_data : w0;
      w0 <= rd_data;
      out_valid    <= out_en;
      image_output <= out_en ? med3(w1, w0, rd_data) : 8'd0;
      finish       <= finish | last | (state == DONE);
    end
  end

endmodule

// File: tb/tb_median_filter.sv
// Directed bench for median_filter: two instances (DEPTH 4096 and 4) with a
// scoreboard of expected medians checked cycle-exactly against out_valid.
module tb_median_filter;

  logic       clk;
  logic       rst;
  logic [7:0] pix;
  logic [1:0] en, ep;
  logic [7:0] io  [2];
  logic       ov  [2];
  logic       fin [2];
  logic       ovf [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] img[$];
  logic [7:0] sb[$];

  median_filter #(.DEPTH(4096), .AW(12)) u0 (
    .clk(clk), .rst(rst), .image_input(pix), .enable(en[0]),
    .enable_process(ep[0]), .image_output(io[0]), .out_valid(ov[0]),
    .finish(fin[0]), .overflow(ovf[0]));

  median_filter #(.DEPTH(4), .AW(2)) u1 (
    .clk(clk), .rst(rst), .image_input(pix), .enable(en[1]),
    .enable_process(ep[1]), .image_output(io[1]), .out_valid(ov[1]),
    .finish(fin[1]), .overflow(ovf[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mid3(input logic [7:0] a, b, c);
    if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
    if ((b <= a && a <= c) || (c <= a && a <= b)) return a;
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int d, input logic [7:0] v);
    pix   = v;
    en[d] = 1'b1;
    tick();
    en[d] = 1'b0;
    img.push_back(v);
  endtask

  // Pulse enable_process, then check every cycle up to a few past finish.
  // rst_at != 0 asserts rst before edge E0+rst_at and expects quiet outputs.
  task automatic run(input int d, input int depth, input int rst_at);
    int n, lo, hi;
    logic ev, ef;
    n = (img.size() < depth) ? img.size() : depth;
    for (int k = 0; k < n; k++) begin
      lo = (k == 0) ? 0 : k - 1;
      hi = (k == n - 1) ? n - 1 : k + 1;
      sb.push_back(mid3(img[lo], img[k], img[hi]));
    end
    ep[d] = 1'b1;
    tick();
    ep[d] = 1'b0;
    chk("valid_E0", 16'(ov[d]), 16'd0);
    for (int j = 1; j <= n + 4; j++) begin
      if (rst_at != 0 && j == rst_at) rst = 1'b1;
      tick();
      if (rst_at != 0 && j >= rst_at) begin
        chk("valid_rst", 16'(ov[d]), 16'd0);
        chk("finish_rst", 16'(fin[d]), 16'd0);
      end else begin
        ev = (n > 0) && (j >= 3) && (j < 3 + n);
        ef = (n == 0) || (j >= 3 + n);
        chk($sformatf("valid_E%0d", j), 16'(ov[d]), 16'(ev));
        chk($sformatf("finish_E%0d", j), 16'(fin[d]), 16'(ef));
        if (ev && sb.size() > 0) chk($sformatf("pix_E%0d", j), 16'(io[d]), 16'(sb.pop_front()));
        else chk($sformatf("zero_E%0d", j), 16'(io[d]), 16'd0);
      end
    end
    rst = 1'b0;
    sb.delete();
    img.delete();
  endtask

  initial begin
    rst = 1'b1; pix = '0; en = '0; ep = '0;
    // Reset with random inputs on the other pins
    for (int i = 0; i < 2; i++) begin
      pix = 8'($urandom);
      en  = 2'($urandom);
      ep  = 2'($urandom);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      chk("rst_out",  16'(io[d]),  16'd0);
      chk("rst_vld",  16'(ov[d]),  16'd0);
      chk("rst_fin",  16'(fin[d]), 16'd0);
      chk("rst_ovf",  16'(ovf[d]), 16'd0);
    end
    en = '0; ep = '0; rst = 1'b0;
    tick();

    // Basic five-pixel image with an outlier
    load(0, 8'd10); load(0, 8'd200); load(0, 8'd30); load(0, 8'd40); load(0, 8'd50);
    run(0, 4096, 0);

    // Single pixel
    do_reset();
    load(0, 8'd77);
    run(0, 4096, 0);

    // Two pixels
    do_reset();
    load(0, 8'd9); load(0, 8'd3);
    run(0, 4096, 0);

    // Empty image
    do_reset();
    run(0, 4096, 0);

    // Overflow on the small-buffer instance
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(1, 8'(5 + i));
      chk($sformatf("ovf_w%0d", i + 1), 16'(ovf[1]), 16'(i >= 4));
    end
    run(1, 4, 0);
    chk("ovf_sticky", 16'(ovf[1]), 16'd1);
    do_reset();
    chk("ovf_cleared", 16'(ovf[1]), 16'd0);

    // Random image
    for (int i = 0; i < 20; i++) load(0, 8'($urandom));
    run(0, 4096, 0);

    // Reset mid-run, then reload a fresh image
    do_reset();
    for (int i = 1; i <= 6; i++) load(0, 8'(i));
    run(0, 4096, 4);
    tick();
    load(0, 8'd0); load(0, 8'd255); load(0, 8'd0);
    run(0, 4096, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/median_filter.md
# median_filter

Three-tap 1-D median (salt-and-pepper denoise) stage that sits directly upstream of the brightness stage. It consumes the raw noisy pixel stream, buffers the whole image, and replays it as a denoised stream for the brightness stage to consume. It uses the same load/process/finish protocol as the rest of the filter chain. One pixel is emitted per cycle, with an explicit valid qualifier.

## Interface
- DEPTH, 4096, pixel buffer capacity in pixels (power of two)
- AW, 12, address width, log2(DEPTH)
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high
- image_input  in  8  unsigned pixel, written while loading
- enable  in  1  load strobe; one pixel is written per cycle while high
- enable_process  in  1  start of processing; sampled only in LOAD
- image_output  out  8  median pixel; 0 whenever out_valid is low
- out_valid  out  1  image_output carries a valid pixel this cycle
- finish  out  1  all pixels emitted; sticky until rst
- overflow  out  1  a load was attempted with the buffer full; sticky until rst

## Operation
- Clocking and reset: one clock, clk. rst is synchronous and active-high, and it dominates every other input on the edge where it is sampled.
- Reset values:
  - state = LOAD
  - write count N = 0, read pointer = 0
  - image_output = 0, out_valid = 0, finish = 0, overflow = 0
  - Buffer contents are not cleared.
- States: LOAD -> PROC -> DONE.
- LOAD:
  - enable=1 and enable_process=0: mem[N] <= image_input and N++.
  - If N==DEPTH, the write is dropped, N is held and overflow <= 1.
  - enable_process=1 (whatever the value of enable): no write that cycle. Go to PROC, or straight to DONE if N==0.
- PROC:
  - Pixels k = 0..N-1 are emitted in order.
  - Output k = median(p[k-1], p[k], p[k+1]).
  - Indices clamp at the edges: p[-1] = p[0] and p[N] = p[N-1].
  - Median network: max(min(a,b), min(max(a,b),c)). It is 8-bit unsigned, with no rounding and no widening.
  - Implementation: a synchronous-read buffer feeding a 3-deep window shift register, plus one output register.
  - enable and enable_process are ignored in PROC. A run always completes unless rst is asserted.
- DONE: finish=1 and out_valid=0. All inputs except rst are ignored.
- Edge cases:
  - N==1: the single output equals p[0].
  - N==2: the outputs are p[0], p[1].
- Reset in the middle of a run returns the block to LOAD with N=0. A fresh image must then be loaded.

## Timing
- Let E0 be the edge that samples enable_process=1 in LOAD.
- Output k is registered at edge E0+3+k. out_valid is high for exactly N consecutive cycles, with no bubbles.
- finish rises at edge E0+3+N, the edge after the last valid output, at which point out_valid=0.
- N==0: finish rises at E0+1, and out_valid never asserts.
- Throughput: 1 pixel/clk in both phases.
- A load pixel presented at edge t is readable in PROC from any later cycle. There is no write-to-read hazard because the phases are disjoint.
- The downstream stage may treat out_valid as its per-pixel enable. There is no backpressure.
- rst sampled at edge t: all outputs hold their reset values from t onward.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> image_output=0, out_valid=0, finish=0, overflow=0.
- Load 10,200,30,40,50, then pulse enable_process -> out_valid at E0+3..E0+7 carrying 10,30,40,40,50; finish=1 at E0+8.
- Load a single pixel 77 and process -> one valid output, 77, at E0+3; finish at E0+4.
- Zero pixels loaded, enable_process=1 -> finish at E0+1; out_valid never high.
- DEPTH=4: load 5,6,7,8,9,10 -> overflow=1 after the 5th write; processing emits 4 pixels: 5,6,7,8.
- Assert rst at E0+4 during a run -> out_valid=0 and finish=0 from that edge on. Then reload 0,255,0 and process -> outputs 0,0,0 with finish at E0'+6.
